mem_wr_queue: RTL and testbench

MEM_WR_QUEUE -- requirements
Module: mem_wr_queue

---
 rtl/mem_wr_queue.sv | 118 +++++++++++
 tb/tb_mem_wr_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wr_queue.sv
// Write queue between mem_controller and the host link, with outstanding-write throttling.
// Define MEM_WR_QUEUE_STATS_EN to build the saturating stall_cycles counter.
module mem_wr_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_go,
  input  logic [63:0]  wr_addr,
  input  logic [511:0] wr_data,
  output logic         full,
  output logic         wr_done,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [63:0]  tx_addr,
  output logic [511:0] tx_data,
  input  logic         tx_ack,
  output logic         idle,
  output logic [31:0]  stall_cycles
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_THROTTLE, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] out_q, out_d;
  logic          tx_valid_q, idle_q;
  logic          issue, ack_eff;

  logic [63:0]   addr_mem [DEPTH];
  logic [511:0]  data_mem [DEPTH];

  assign full     = (cnt_q == CW'(DEPTH));
  assign wr_done  = wr_go & ~full;
  assign tx_valid = tx_valid_q;
  assign idle     = idle_q;
  assign issue    = tx_valid_q & tx_ready;
  // Acks arriving with nothing outstanding (e.g. from before a reset) are dropped.
  assign ack_eff  = tx_ack & (out_q != '0);

  assign tx_addr  = {addr_mem[head_q][63:6], 6'b0};
  assign tx_data  = data_mem[head_q];

  always_ff @(posedge clk) begin
    if (wr_done) begin
      addr_mem[tail_q] <= wr_addr;
      data_mem[tail_q] <= wr_data;
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (wr_done) tail_d = tail_q + PW'(1);
    if (issue)   head_d = head_q + PW'(1);
    unique case ({wr_done, issue})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    unique case ({issue, ack_eff})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
    // State reflects the counts that will hold after this edge, so tx_valid/idle track them exactly.
    if (cnt_d == '0 && out_d == '0) state_d = S_IDLE;
    else if (cnt_d == '0)           state_d = S_DRAIN;
    else if (out_d < OW'(MAX_OUT))  state_d = S_SEND;
    else                            state_d = S_THROTTLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      tx_valid_q <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      tx_valid_q <= (state_d == S_SEND);
      idle_q     <= (state_d == S_IDLE);
    end
  end

`ifdef MEM_WR_QUEUE_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (wr_go && full && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wr_queue.sv
// Bench for mem_wr_queue (DEPTH=4, MAX_OUT=2): queue/counter reference model checked every cycle
// plus directed literal checks for write, full, throttle, simultaneous events, alignment and reset.
module tb_mem_wr_queue;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_go;
  logic [63:0]  wr_addr;
  logic [511:0] wr_data;
  logic         full, wr_done, tx_valid, tx_ready, tx_ack, idle;
  logic [63:0]  tx_addr;
  logic [511:0] tx_data;
  logic [31:0]  stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wr_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .wr_go(wr_go), .wr_addr(wr_addr), .wr_data(wr_data),
    .full(full), .wr_done(wr_done), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_addr(tx_addr), .tx_data(tx_data), .tx_ack(tx_ack), .idle(idle),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: a plain FIFO of accepted requests and an outstanding-write integer.
  logic [63:0]  mq_addr [$];
  logic [511:0] mq_data [$];
  int           m_out   = 0;
  longint       m_stall = 0;

  always @(negedge clk) begin
    bit e_full, e_done, e_valid, e_idle, e_issue;
    logic [31:0] e_stall;
    if (rst) begin
      mq_addr.delete();
      mq_data.delete();
      m_out   = 0;
      m_stall = 0;
      check("rst_full", full, 0);
      check("rst_wr_done", wr_done, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_idle", idle, 1);
      check("rst_stall", stall_cycles, 0);
    end else begin
      e_full  = (mq_addr.size() == DEPTH);
      e_done  = wr_go && !e_full;
      e_valid = (mq_addr.size() > 0) && (m_out < MAX_OUT);
      e_idle  = (mq_addr.size() == 0) && (m_out == 0);
      e_issue = e_valid && tx_ready;
`ifdef MEM_WR_QUEUE_STATS_EN
      e_stall = 32'(m_stall);
`else
      e_stall = 32'd0;
`endif
      check("full", full, e_full);
      check("wr_done", wr_done, e_done);
      check("tx_valid", tx_valid, e_valid);
      check("idle", idle, e_idle);
      check("stall_cycles", stall_cycles, e_stall);
      if (e_valid) begin
        check("tx_addr", tx_addr, {mq_addr[0][63:6], 6'b0});
        check("tx_data", tx_data, mq_data[0]);
      end
      // Advance the model to what the coming rising edge must produce.
      if (tx_ack) begin
        $display("ack  outstanding=%0d%s", m_out, (m_out == 0) ? " (ignored)" : "");
        if (m_out > 0) m_out--;
      end
      if (e_issue) begin
        $display("iss  addr=%h", {mq_addr[0][63:6], 6'b0});
        void'(mq_addr.pop_front());
        void'(mq_data.pop_front());
        m_out++;
      end
      if (e_done) begin
        $display("acc  addr=%h", wr_addr);
        mq_addr.push_back(wr_addr);
        mq_data.push_back(wr_data);
      end
      if (wr_go && e_full && m_stall < 64'hFFFF_FFFF) m_stall++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; wr_go = 0; wr_addr = '0; wr_data = '0; tx_ready = 0; tx_ack = 0;
    #1;
    check("lit_rst_idle", idle, 1);
    check("lit_rst_valid", tx_valid, 0);
    step(2);
    rst = 1'b0;
    step(1);

    // Basic write
    wr_go = 1; wr_addr = 64'h1000_0040; wr_data = 512'hA5;
    #1 check("lit_basic_done", wr_done, 1);
    step(1);
    wr_go = 0;
    #1 check("lit_basic_valid", tx_valid, 1);
    check("lit_basic_addr", tx_addr, 64'h1000_0040);
    tx_ready = 1;
    step(1);
    tx_ready = 0;
    #1 check("lit_basic_drain_idle", idle, 0);
    tx_ack = 1;
    step(1);
    tx_ack = 0;
    #1 check("lit_basic_idle", idle, 1);

    // Fill to DEPTH, fifth request refused
    for (int i = 0; i < 5; i++) begin
      wr_go = 1; wr_addr = 64'h2000_0000 + 64'(i) * 64'h40; wr_data = 512'(32'hD0 + i);
      if (i == 4) begin
        #1 check("lit_full_full", full, 1);
        check("lit_full_done", wr_done, 0);
      end
      step(1);
    end
    wr_go = 0;
`ifdef MEM_WR_QUEUE_STATS_EN
    #1 check("lit_stall", stall_cycles, 1);
`else
    #1 check("lit_stall", stall_cycles, 0);
`endif

    // Throttle at MAX_OUT, then release one slot with an ack
    tx_ready = 1;
    step(2);
    #1 check("lit_throttle_valid", tx_valid, 0);
    check("lit_throttle_idle", idle, 0);
    tx_ack = 1;
    step(1);
    tx_ack = 0;
    #1 check("lit_unthrottle_valid", tx_valid, 1);
    check("lit_unthrottle_addr", tx_addr, 64'h2000_0080);
    step(1);
    tx_ack = 1;
    step(6);
    tx_ack = 0; tx_ready = 0;
    #1 check("lit_after_drain_idle", idle, 1);

    // Simultaneous accept+issue+ack at occupancy 2
    for (int i = 0; i < 2; i++) begin
      wr_go = 1; wr_addr = 64'h3000_0000 + 64'(i) * 64'h40; wr_data = 512'(32'hB0 + i);
      step(1);
    end
    wr_go = 0; tx_ready = 1;
    step(1);
    tx_ready = 0; wr_go = 1; wr_addr = 64'h3000_0080; wr_data = 512'hB2;
    step(1);
    wr_go = 1; wr_addr = 64'h3000_00C0; wr_data = 512'hB3; tx_ready = 1; tx_ack = 1;
    step(1);
    wr_go = 0; tx_ready = 0; tx_ack = 0;
    #1 check("lit_simul_full", full, 0);
    check("lit_simul_valid", tx_valid, 1);
    check("lit_simul_addr", tx_addr, 64'h3000_0080);
    tx_ready = 1; tx_ack = 1;
    step(6);
    tx_ready = 0; tx_ack = 0;
    #1 check("lit_simul_idle", idle, 1);

    // Alignment, then reset with 3 entries queued
    wr_go = 1; wr_addr = 64'h0000_0000_0000_107F; wr_data = 512'hC0;
    step(1);
    wr_go = 0;
    #1 check("lit_align_addr", tx_addr, 64'h1040);
    for (int i = 0; i < 2; i++) begin
      wr_go = 1; wr_addr = 64'h4000_0000 + 64'(i) * 64'h40; wr_data = 512'(32'hC1 + i);
      step(1);
    end
    wr_go = 0;
    rst = 1;
    #1 check("lit_rst_mid_valid", tx_valid, 0);
    check("lit_rst_mid_idle", idle, 1);
    check("lit_rst_mid_full", full, 0);
    step(2);
    rst = 0; tx_ack = 1;
    step(1);
    tx_ack = 0;
    #1 check("lit_stale_ack_idle", idle, 1);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
